// File: rtl/tff_count_sequencer_if.sv
// Interface bundling the control inputs and status outputs of tff_count_sequencer.
// The master drives the controls and observes the status; the slave is the sequencer.
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic [1:0]       state;

    modport master (
        output start, pause, load, load_val, up_dn, limit,
        input  t, count, busy, tc, state
    );

    modport slave (
        input  start, pause, load, load_val, up_dn, limit,
        output t, count, busy, tc, state
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: drives a WIDTH-bit toggle flip-flop bank (count <= count ^ t)
// so that it behaves as an up/down modulo counter with start, pause, load and
// terminal-count pulse.
// Optional build macro: ONE_SHOT_EN -- when defined, the wrap step in RUN returns
// the FSM to IDLE instead of counting on.
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tff_count_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LOAD  = 2'b11
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             busy_r;
    logic             from_idle_r;   // LOAD was entered from IDLE, so it returns there

    logic             up_wrap_s;
    logic             dn_wrap_s;
    logic             wrap_s;
    logic [WIDTH-1:0] step_next_s;
    logic [WIDTH-1:0] load_clamp_s;
    logic [WIDTH-1:0] next_count_s;
    logic             step_en_s;
    logic [WIDTH-1:0] t_s;

    // Candidate next value for a RUN step, wrap detection and clamped load value.
    always_comb begin
        up_wrap_s = (count_r >= bus.limit);
        dn_wrap_s = (count_r == {WIDTH{1'b0}}) || (count_r > bus.limit);
        if (bus.up_dn) begin
            wrap_s = up_wrap_s;
            if (up_wrap_s) begin
                step_next_s = {WIDTH{1'b0}};
            end else begin
                step_next_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            wrap_s = dn_wrap_s;
            if (dn_wrap_s) begin
                step_next_s = bus.limit;
            end else begin
                step_next_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
        if (bus.load_val > bus.limit) begin
            load_clamp_s = bus.limit;
        end else begin
            load_clamp_s = bus.load_val;
        end
    end

    // Next bank value for this cycle; the toggle vector is its difference from count.
    always_comb begin
        next_count_s = count_r;
        step_en_s    = 1'b0;
        if (rst) begin
            next_count_s = count_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!bus.load && !bus.pause) begin
                        next_count_s = step_next_s;
                        step_en_s    = 1'b1;
                    end else begin
                        next_count_s = count_r;
                    end
                end
                ST_LOAD: begin
                    next_count_s = load_clamp_s;
                end
                default: begin
                    next_count_s = count_r;
                end
            endcase
        end
        t_s = count_r ^ next_count_s;
    end

    // Toggle bank, terminal-count pulse and control FSM with registered busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {WIDTH{1'b0}};
            tc_r        <= 1'b0;
            busy_r      <= 1'b0;
            from_idle_r <= 1'b0;
            state_r     <= ST_IDLE;
        end else begin
            count_r <= count_r ^ t_s;
            tc_r    <= step_en_s & wrap_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.load) begin
                        state_r     <= ST_LOAD;
                        from_idle_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (bus.start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.load) begin
                        state_r     <= ST_LOAD;
                        from_idle_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (bus.pause) begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b0;
`ifdef ONE_SHOT_EN
                    end else if (wrap_s) begin
                        // Wrap step completes, then the sequence stops.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.load) begin
                        state_r     <= ST_LOAD;
                        from_idle_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (!bus.pause) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (from_idle_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.pause) begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.t     = t_s;
    assign bus.count = count_r;
    assign bus.busy  = busy_r;
    assign bus.tc    = tc_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Scoreboard bench for tff_count_sequencer: the stimulus process pushes the
// hand-computed expected outputs for each cycle; the monitor pops and compares
// them on the falling edge.
module tb_tff_count_sequencer;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] LOAD  = 2'b11;

    typedef struct {
        int         tag;
        logic [3:0] count;
        logic [1:0] state;
        logic       tc;
        logic       busy;
        logic [3:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    tff_count_sequencer_if #(.WIDTH(4)) bus ();

    tff_count_sequencer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected outputs at the coming falling edge: registers after the edge just
    // passed, t from the inputs just driven.
    task automatic ex(input int tag, input logic [3:0] c, input logic [1:0] s,
                      input logic tc, input logic [3:0] t);
        exp_t e;
        e.tag   = tag;
        e.count = c;
        e.state = s;
        e.tc    = tc;
        e.busy  = (s == RUN);
        e.t     = t;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input int tag, input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL step %0d %s: got %0d, expected %0d", tag, name, got, want);
        end
    endtask

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.tag, "count", int'(bus.count), int'(e.count));
            cmp(e.tag, "state", int'(bus.state), int'(e.state));
            cmp(e.tag, "tc",    int'(bus.tc),    int'(e.tc));
            cmp(e.tag, "busy",  int'(bus.busy),  int'(e.busy));
            cmp(e.tag, "t",     int'(bus.t),     int'(e.t));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.load = 1'b0;
        bus.load_val = 4'd0; bus.up_dn = 1'b1; bus.limit = 4'd9;

        // Reset mid-run at count 5.
        tick(); rst = 1'b1;                        ex(1, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); rst = 1'b0; bus.start = 1'b1;      ex(2, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); bus.start = 1'b0;                  ex(3, 4'd0, RUN,  1'b0, 4'd1);
        tick();                                    ex(4, 4'd1, RUN,  1'b0, 4'd3);
        tick();                                    ex(5, 4'd2, RUN,  1'b0, 4'd1);
        tick();                                    ex(6, 4'd3, RUN,  1'b0, 4'd7);
        tick();                                    ex(7, 4'd4, RUN,  1'b0, 4'd1);
        tick(); rst = 1'b1;                        ex(8, 4'd5, RUN,  1'b0, 4'd0);
        tick();                                    ex(9, 4'd0, IDLE, 1'b0, 4'd0);

        // Up count modulo 4.
        tick(); rst = 1'b0; bus.limit = 4'd3; bus.start = 1'b1;
                                                   ex(10, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); bus.start = 1'b0;                  ex(11, 4'd0, RUN,  1'b0, 4'd1);
        tick();                                    ex(12, 4'd1, RUN,  1'b0, 4'd3);
        tick();                                    ex(13, 4'd2, RUN,  1'b0, 4'd1);
        tick();                                    ex(14, 4'd3, RUN,  1'b0, 4'd3);
`ifdef ONE_SHOT_EN
        tick();                                    ex(15, 4'd0, IDLE, 1'b1, 4'd0);
        tick(); rst = 1'b1;                        ex(16, 4'd0, IDLE, 1'b0, 4'd0);
`else
        tick();                                    ex(15, 4'd0, RUN,  1'b1, 4'd1);
        tick(); rst = 1'b1;                        ex(16, 4'd1, RUN,  1'b0, 4'd0);
`endif

        // Down count modulo 10 from 0.
        tick(); rst = 1'b0; bus.limit = 4'd9; bus.up_dn = 1'b0; bus.start = 1'b1;
                                                   ex(17, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); bus.start = 1'b0;                  ex(18, 4'd0, RUN,  1'b0, 4'b1001);
`ifdef ONE_SHOT_EN
        tick();                                    ex(19, 4'd9, IDLE, 1'b1, 4'd0);
        tick();                                    ex(20, 4'd9, IDLE, 1'b0, 4'd0);
        tick(); rst = 1'b1;                        ex(21, 4'd9, IDLE, 1'b0, 4'd0);
`else
        tick();                                    ex(19, 4'd9, RUN,  1'b1, 4'd1);
        tick();                                    ex(20, 4'd8, RUN,  1'b0, 4'd15);
        tick(); rst = 1'b1;                        ex(21, 4'd7, RUN,  1'b0, 4'd0);
`endif

        // Load with pause in the same cycle, clamped to limit.
        tick(); rst = 1'b0; bus.up_dn = 1'b1; bus.limit = 4'd10; bus.start = 1'b1;
                                                   ex(22, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); bus.start = 1'b0;                  ex(23, 4'd0, RUN,  1'b0, 4'd1);
        tick();                                    ex(24, 4'd1, RUN,  1'b0, 4'd3);
        tick();                                    ex(25, 4'd2, RUN,  1'b0, 4'd1);
        tick();                                    ex(26, 4'd3, RUN,  1'b0, 4'd7);
        tick(); bus.load = 1'b1; bus.pause = 1'b1; bus.load_val = 4'd12;
                                                   ex(27, 4'd4, RUN,  1'b0, 4'd0);
        tick(); bus.load = 1'b0;                   ex(28, 4'd4, LOAD, 1'b0, 4'd14);
        tick();                                    ex(29, 4'd10, PAUSE, 1'b0, 4'd0);
        tick();                                    ex(30, 4'd10, PAUSE, 1'b0, 4'd0);

        // Load 6 from PAUSE, then pause for 3 cycles and resume.
        tick(); bus.load = 1'b1; bus.load_val = 4'd6; bus.pause = 1'b0;
                                                   ex(31, 4'd10, PAUSE, 1'b0, 4'd0);
        tick(); bus.load = 1'b0;                   ex(32, 4'd10, LOAD,  1'b0, 4'd12);
        tick(); bus.pause = 1'b1;                  ex(33, 4'd6, RUN,    1'b0, 4'd0);
        tick();                                    ex(34, 4'd6, PAUSE,  1'b0, 4'd0);
        tick();                                    ex(35, 4'd6, PAUSE,  1'b0, 4'd0);
        tick(); bus.pause = 1'b0;                  ex(36, 4'd6, PAUSE,  1'b0, 4'd0);
        tick();                                    ex(37, 4'd6, RUN,    1'b0, 4'd1);
        tick();                                    ex(38, 4'd7, RUN,    1'b0, 4'd15);

        // Limit lowered below the current count while running up.
        tick(); bus.limit = 4'd5;                  ex(39, 4'd8, RUN,    1'b0, 4'd8);
`ifdef ONE_SHOT_EN
        tick();                                    ex(40, 4'd0, IDLE,   1'b1, 4'd0);
        tick();                                    ex(41, 4'd0, IDLE,   1'b0, 4'd0);
        tick(); rst = 1'b1;                        ex(42, 4'd0, IDLE,   1'b0, 4'd0);
`else
        tick();                                    ex(40, 4'd0, RUN,    1'b1, 4'd1);
        tick();                                    ex(41, 4'd1, RUN,    1'b0, 4'd3);
        tick(); rst = 1'b1;                        ex(42, 4'd2, RUN,    1'b0, 4'd0);
`endif

        // Load from IDLE returns to IDLE.
        tick(); rst = 1'b0; bus.load = 1'b1; bus.load_val = 4'd3;
                                                   ex(43, 4'd0, IDLE, 1'b0, 4'd0);
        tick(); bus.load = 1'b0;                   ex(44, 4'd0, LOAD, 1'b0, 4'd3);
        tick();                                    ex(45, 4'd3, IDLE, 1'b0, 4'd0);

        // limit = 0: count pinned at 0, tc every cycle.
        tick(); bus.limit = 4'd0; bus.start = 1'b1; ex(46, 4'd3, IDLE, 1'b0, 4'd0);
        tick(); bus.start = 1'b0;                  ex(47, 4'd3, RUN,  1'b0, 4'd3);
`ifdef ONE_SHOT_EN
        tick();                                    ex(48, 4'd0, IDLE, 1'b1, 4'd0);
        tick();                                    ex(49, 4'd0, IDLE, 1'b0, 4'd0);
        tick();                                    ex(50, 4'd0, IDLE, 1'b0, 4'd0);
`else
        tick();                                    ex(48, 4'd0, RUN,  1'b1, 4'd0);
        tick();                                    ex(49, 4'd0, RUN,  1'b1, 4'd0);
        tick();                                    ex(50, 4'd0, RUN,  1'b1, 4'd0);
`endif

        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
